// File: rtl/score_link_pkg.sv
// score_link_pkg: ASCII constants, FSM encodings and BCD-to-ASCII helper for the score link framer.
package score_link_pkg;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GUARD, TX_WAIT} tx_state_e;
  typedef enum logic [1:0] {RX_HDR, RX_DIG, RX_CR, RX_LF} rx_state_e;
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] n);
    return (n > 4'd9) ? ASCII_QMARK : ASCII_ZERO + {4'd0, n};
  endfunction
endpackage

// File: rtl/score_link_if.sv
// score_link_if: score path and UART byte-level signals of the score link framer.
interface score_link_if #(parameter int DIGITS = 6);
  logic [4*DIGITS-1:0] score_bcd;
  logic [4*DIGITS-1:0] peer_score;
  logic                send_req;
  logic                tx_busy;
  logic [7:0]          tx_data;
  logic                tx_wr;
  logic [7:0]          rx_data;
  logic                rx_rdy;
  logic                rx_rdy_clr;
  logic                peer_valid;
  logic                rx_err;
  logic                tx_active;
  modport master (
    output score_bcd, send_req, tx_busy, rx_data, rx_rdy,
    input  tx_data, tx_wr, rx_rdy_clr, peer_score, peer_valid, rx_err, tx_active
  );
  modport slave (
    input  score_bcd, send_req, tx_busy, rx_data, rx_rdy,
    output tx_data, tx_wr, rx_rdy_clr, peer_score, peer_valid, rx_err, tx_active
  );
endinterface

// File: rtl/score_link_rx_parser.sv
// score_link_rx_parser: parses peer score frames from UART bytes into a BCD peer score.
module score_link_rx_parser
  import score_link_pkg::*;
#(
  parameter int         DIGITS   = 6,
  parameter logic [7:0] HDR_CHAR = 8'h53
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_rdy_i,
  output logic                rx_rdy_clr_o,
  output logic [4*DIGITS-1:0] peer_score_o,
  output logic                peer_valid_o,
  output logic                rx_err_o
);
  localparam int CW = $clog2(DIGITS + 1);
  rx_state_e           state_q;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] shadow_q, peer_q;
  logic                clr_q, valid_q, err_q;
  logic                accept, is_hdr, is_digit, ok;
  always_comb begin
    accept   = rx_rdy_i && !clr_q;
    is_hdr   = rx_data_i == HDR_CHAR;
    is_digit = rx_data_i >= ASCII_ZERO && rx_data_i <= ASCII_ZERO + 8'd9;
    ok       = state_q == RX_DIG ? is_digit :
               state_q == RX_CR  ? rx_data_i == ASCII_CR : rx_data_i == ASCII_LF;
  end
  // A header byte arriving where it is not expected restarts the frame after flagging the error.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= RX_HDR;
      cnt_q    <= '0;
      shadow_q <= '0;
      peer_q   <= '0;
      clr_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      clr_q   <= accept;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        if (state_q == RX_HDR || !ok) begin
          err_q    <= state_q != RX_HDR;
          state_q  <= is_hdr ? RX_DIG : RX_HDR;
          cnt_q    <= '0;
          shadow_q <= '0;
        end else begin
          case (state_q)
            RX_DIG: begin
              shadow_q <= {shadow_q[4*DIGITS-5:0], rx_data_i[3:0]};
              cnt_q    <= cnt_q + CW'(1);
              state_q  <= cnt_q == CW'(DIGITS - 1) ? RX_CR : RX_DIG;
            end
            RX_CR: state_q <= RX_LF;
            default: begin
              peer_q  <= shadow_q;
              valid_q <= 1'b1;
              state_q <= RX_HDR;
            end
          endcase
        end
      end
    end
  end
  assign rx_rdy_clr_o = clr_q;
  assign peer_score_o = peer_q;
  assign peer_valid_o = valid_q;
  assign rx_err_o     = err_q;
endmodule

// File: rtl/score_link_framer.sv
// score_link_framer: frames the local BCD score as ASCII packets over UART and parses the peer's packets.
module score_link_framer
  import score_link_pkg::*;
#(
  parameter int          DIGITS         = 6,
  parameter logic [7:0]  HDR_CHAR       = 8'h53,
  parameter int unsigned REFRESH_CYCLES = 75_000_000
) (
  input logic        pclk,
  input logic        rst,
  score_link_if.slave lk
);
  localparam int NB = DIGITS + 3;
  localparam int IW = $clog2(NB);
  tx_state_e           state_q;
  logic [IW-1:0]       idx_q, nidx;
  logic [4*DIGITS-1:0] last_sent_q;
  logic                pending_q, tx_wr_q;
  logic [7:0]          tx_data_q, next_byte;
  logic [31:0]         refresh_q, refresh_d;
  logic [3:0]          nib;
  logic                start, trig, last;
  always_comb begin
    start = state_q == TX_IDLE && pending_q;
    last  = idx_q == IW'(NB - 1);
    nidx  = idx_q + IW'(1);
    nib   = '0;
    for (int i = 0; i < DIGITS; i++)
      if (int'(nidx) == i + 1) nib = last_sent_q[4*(DIGITS-1-i) +: 4];
    next_byte = int'(nidx) == DIGITS + 1 ? ASCII_CR :
                int'(nidx) == DIGITS + 2 ? ASCII_LF : bcd_to_ascii(nib);
    refresh_d = (start || REFRESH_CYCLES == 0 || refresh_q == 32'(REFRESH_CYCLES - 1)) ?
                '0 : refresh_q + 32'd1;
    // Raising pending as the counter lands on its last value keeps frame starts exactly REFRESH_CYCLES apart.
    trig = REFRESH_CYCLES != 0 && refresh_d == 32'(REFRESH_CYCLES - 1);
  end
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= TX_IDLE;
      idx_q       <= '0;
      last_sent_q <= '0;
      pending_q   <= 1'b0;
      refresh_q   <= '0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      refresh_q <= refresh_d;
      pending_q <= !start && (pending_q || trig || lk.send_req || lk.score_bcd != last_sent_q);
      tx_wr_q   <= 1'b0;
      case (state_q)
        TX_IDLE: if (pending_q) begin
          state_q     <= TX_SEND;
          last_sent_q <= lk.score_bcd;
          idx_q       <= '0;
          tx_wr_q     <= 1'b1;
          tx_data_q   <= HDR_CHAR;
        end
        TX_SEND:  state_q <= TX_GUARD;
        TX_GUARD: state_q <= TX_WAIT;
        default: if (!lk.tx_busy) begin
          if (last) state_q <= TX_IDLE;
          else begin
            state_q   <= TX_SEND;
            idx_q     <= nidx;
            tx_wr_q   <= 1'b1;
            tx_data_q <= next_byte;
          end
        end
      endcase
    end
  end
  assign lk.tx_data   = tx_data_q;
  assign lk.tx_wr     = tx_wr_q;
  assign lk.tx_active = state_q != TX_IDLE;
  score_link_rx_parser #(.DIGITS(DIGITS), .HDR_CHAR(HDR_CHAR)) u_rx (
    .pclk         (pclk),
    .rst          (rst),
    .rx_data_i    (lk.rx_data),
    .rx_rdy_i     (lk.rx_rdy),
    .rx_rdy_clr_o (lk.rx_rdy_clr),
    .peer_score_o (lk.peer_score),
    .peer_valid_o (lk.peer_valid),
    .rx_err_o     (lk.rx_err)
  );
endmodule

// File: tb/tb_score_link_framer.sv
// tb_score_link_framer: random and directed checks of framing, pacing, refresh, RX parsing and reset.
module tb_score_link_framer;
  localparam int D = 6, NB = D + 3, R = 100;
  logic pclk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0, cyc = 0, bl = 10, busy_cnt = 0;
  int nbytes = 0, clr_cnt = 0, valid_cnt = 0, err_cnt = 0;
  logic [71:0] cur = '0, frames[$];
  logic [23:0] snap = '0, hist[int];
  int hdr_cyc[$];
  logic [7:0] rx_all[$];
  logic [7:0] pk1[$] = '{8'h53, 8'h30, 8'h30, 8'h35, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
  logic [7:0] pk2[$] = '{8'h53, 8'h31, 8'h32, 8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
  logic [7:0] pk3[$] = '{8'h53, 8'h31, 8'h41};

  score_link_if #(.DIGITS(D)) lk();
  score_link_framer #(.DIGITS(D), .HDR_CHAR(8'h53), .REFRESH_CYCLES(R)) dut (.pclk(pclk), .rst(rst), .lk(lk));

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  // UART transmitter model: busy for bl cycles after each write strobe
  always @(posedge pclk or negedge rst)
    busy_cnt <= !rst ? 0 : lk.tx_wr ? bl : (busy_cnt > 0 ? busy_cnt - 1 : 0);
  assign lk.tx_busy = busy_cnt != 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] frame_of(input logic [23:0] s);
    logic [71:0] f;
    int n;
    f = {8'h53, 48'h0, 8'h0D, 8'h0A};
    for (int i = 0; i < D; i++) begin
      n = int'(s[4*(D-1-i) +: 4]);
      f[8*(7-i) +: 8] = n > 9 ? 8'h3F : 8'(48 + n);
    end
    return f;
  endfunction

  function automatic void rx_model(output logic [23:0] peer, output int nv, output int ne);
    logic [7:0] fb[$];
    int p;
    bit good;
    peer = '0; nv = 0; ne = 0;
    foreach (rx_all[k]) begin
      if (fb.size() == 0) begin
        if (rx_all[k] == 8'h53) fb.push_back(rx_all[k]);
      end else begin
        p = fb.size();
        good = p <= D ? (rx_all[k] >= 8'h30 && rx_all[k] <= 8'h39) :
               p == D + 1 ? rx_all[k] == 8'h0D : rx_all[k] == 8'h0A;
        if (!good) begin
          ne++;
          fb.delete();
          if (rx_all[k] == 8'h53) fb.push_back(8'h53);
        end else begin
          fb.push_back(rx_all[k]);
          if (fb.size() == D + 3) begin
            nv++;
            peer = '0;
            for (int i = 1; i <= D; i++) peer = {peer[19:0], fb[i][3:0]};
            fb.delete();
          end
        end
      end
    end
  endfunction

  // Frame monitor: every completed frame must equal the score present just before its header.
  always @(negedge pclk) begin
    hist[cyc] = lk.score_bcd;
    if (!rst) nbytes = 0;
    else if (lk.tx_wr) begin
      chk("wr_while_busy", lk.tx_busy, 0);
      chk("active_at_wr", lk.tx_active, 1);
      if (nbytes == 0) begin
        snap = hist.exists(cyc - 1) ? hist[cyc - 1] : '0;
        hdr_cyc.push_back(cyc);
      end
      cur = {cur[63:0], lk.tx_data};
      nbytes++;
      if (nbytes == NB) begin
        chk("frame", cur, frame_of(snap));
        frames.push_back(cur);
        nbytes = 0;
      end
    end
    if (lk.rx_rdy_clr) clr_cnt++;
    if (lk.peer_valid) valid_cnt++;
    if (lk.rx_err) err_cnt++;
  end

  task automatic wait_frame(input string tag, input logic [71:0] exp, input int from, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge pclk); #1;
      for (int k = from; k < frames.size(); k++) if (frames[k] === exp) hit = 1;
    end
    total++;
    assert (hit) else begin
      bad++;
      $error("FAIL %s got=none exp=%0h", tag, exp);
    end
  endtask

  task automatic wait_hdr(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && hdr_cyc.size() < n; i++) begin @(negedge pclk); #1; end
    chk(tag, hdr_cyc.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int q;
    q = 0;
    for (int i = 0; i < 800 && q < 3; i++) begin
      @(negedge pclk);
      q = lk.tx_active ? 0 : q + 1;
    end
    chk("idle_timeout", q >= 3, 1);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bit got;
    got = 0;
    @(posedge pclk); #1;
    lk.rx_data = b;
    lk.rx_rdy  = 1'b1;
    rx_all.push_back(b);
    for (int i = 0; i < 20 && !got; i++) begin @(negedge pclk); got = lk.rx_rdy_clr; end
    lk.rx_rdy = 1'b0;
    chk("rx_clr_timeout", got, 1);
  endtask

  task automatic rx_pkt(input logic [7:0] q[$]);
    foreach (q[k]) rx_byte(q[k]);
  endtask

  task automatic check_rx(input string tag);
    logic [23:0] ep;
    int nv, ne;
    @(negedge pclk); #1;
    rx_model(ep, nv, ne);
    chk({tag, "_peer"}, lk.peer_score, ep);
    chk({tag, "_valid"}, valid_cnt, nv);
    chk({tag, "_err"}, err_cnt, ne);
    chk({tag, "_clr"}, clr_cnt, rx_all.size());
  endtask

  task automatic tx_random();
    logic [23:0] s;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < D; i++) s = {s[19:0], 4'($urandom_range(0, 11))};
      bl = $urandom_range(1, 10);
      @(posedge pclk); #1;
      lk.score_bcd = s;
      if ($urandom_range(0, 1) == 1) begin
        lk.send_req = 1'b1;
        @(posedge pclk); #1;
        lk.send_req = 1'b0;
      end
      wait_frame("rand_frame", frame_of(s), frames.size(), 800);
    end
  endtask

  task automatic rx_random();
    logic [7:0] pk[$];
    logic [7:0] junk[5] = '{8'h53, 8'h41, 8'h0D, 8'h39, 8'h0A};
    for (int p = 0; p < 16; p++) begin
      pk.delete();
      pk.push_back(8'h53);
      for (int i = 0; i < D; i++) pk.push_back(8'(8'h30 + $urandom_range(0, 9)));
      pk.push_back(8'h0D);
      pk.push_back(8'h0A);
      if ($urandom_range(0, 2) == 0) pk[$urandom_range(1, 8)] = junk[$urandom_range(0, 4)];
      rx_pkt(pk);
      check_rx("rx_rand");
    end
  endtask

  initial begin
    int n, m;
    lk.score_bcd = '0;
    lk.send_req  = 1'b0;
    lk.rx_data   = '0;
    lk.rx_rdy    = 1'b0;
    #2 rst = 1'b0;
    #10;
    chk("reset_outs", {lk.tx_wr, lk.tx_active, lk.rx_rdy_clr, lk.peer_valid, lk.rx_err, lk.tx_data, lk.peer_score}, 0);
    @(posedge pclk); #1 rst = 1'b1;

    @(posedge pclk); #1;
    lk.score_bcd = 24'h001234;
    n = cyc;
    m = frames.size();
    wait_frame("frame_1234", 72'h53_30_30_31_32_33_34_0D_0A, m, 400);
    chk("first_frame", frames[m], 72'h53_30_30_31_32_33_34_0D_0A);
    chk("latency", hdr_cyc[0], n + 2);

    for (int i = 0; i < 400 && nbytes != 3; i++) begin @(negedge pclk); #1; end
    chk("reach_byte3", nbytes, 3);
    @(posedge pclk); #1;
    lk.score_bcd = 24'h000099;
    m = frames.size();
    for (int i = 0; i < 600 && frames.size() < m + 2; i++) begin @(negedge pclk); #1; end
    chk("no_tear_old", frames[m], 72'h53_30_30_31_32_33_34_0D_0A);
    chk("follow_new", frames[m + 1], 72'h53_30_30_30_30_39_39_0D_0A);

    @(posedge pclk); #1;
    lk.score_bcd = 24'h00A001;
    wait_frame("qmark", 72'h53_30_30_3F_30_30_31_0D_0A, frames.size(), 600);

    rx_pkt(pk1);
    check_rx("rx1");
    chk("rx1_lit", lk.peer_score, 24'h005007);
    chk("rx1_valid_lit", valid_cnt, 1);
    chk("rx1_clr_lit", clr_cnt, 9);
    rx_pkt(pk2);
    check_rx("rx2");
    chk("rx2_lit", {lk.peer_score, 8'(err_cnt)}, {24'h000001, 8'd1});
    rx_pkt(pk3);
    check_rx("rx3");
    chk("rx3_lit", {lk.peer_score, 8'(err_cnt)}, {24'h000001, 8'd2});

    bl = 2;
    wait_idle();
    @(posedge pclk); #1;
    lk.score_bcd = 24'h000042;
    n = cyc;
    m = hdr_cyc.size();
    wait_hdr("hdr_42", m + 1, 50);
    chk("latency_idle", hdr_cyc[m], n + 2);
    wait_hdr("refresh_hdr", m + 3, 400);
    chk("refresh_gap1", hdr_cyc[m + 1] - hdr_cyc[m], R);
    chk("refresh_gap2", hdr_cyc[m + 2] - hdr_cyc[m + 1], R);
    wait_idle();
    @(posedge pclk); #1;
    lk.send_req = 1'b1;
    n = cyc;
    m = hdr_cyc.size();
    @(posedge pclk); #1;
    lk.send_req = 1'b0;
    wait_hdr("hdr_req", m + 1, 50);
    chk("send_req_latency", hdr_cyc[m], n + 2);

    fork
      tx_random();
      rx_random();
    join

    bl = 10;
    @(posedge pclk); #1;
    lk.score_bcd = 24'h000777;
    for (int i = 0; i < 800 && nbytes != 4; i++) begin @(negedge pclk); #1; end
    chk("reach_byte4", nbytes, 4);
    rst = 1'b0;
    #1;
    chk("rst_async", {lk.tx_wr, lk.tx_active}, 0);
    repeat (3) @(negedge pclk);
    chk("rst_rx", {lk.peer_score, lk.rx_err, lk.peer_valid}, 0);
    @(posedge pclk); #1 rst = 1'b1;
    m = frames.size();
    wait_frame("resend_777", 72'h53_30_30_30_37_37_37_0D_0A, m, 400);
    chk("resend_first", frames[m], 72'h53_30_30_30_37_37_37_0D_0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_link_framer.md
Name: score_link_framer

Overview:
Sits between the score path (BCD score from the bin-to-BCD converter) and the UART byte interface, directly upstream of the uart transmitter and downstream of its receiver. The TX side frames the local 6-digit BCD score as an ASCII packet and paces bytes through the UART write/busy handshake. The RX side parses the peer's packets back into a BCD peer score for two-player display.

Parameters:
DIGITS, 6, BCD digits per frame; score_bcd width = 4*DIGITS
HDR_CHAR, 8'h53, frame header byte ('S')
REFRESH_CYCLES, 75_000_000, pclk cycles between forced resends (1 s at 75 MHz); 0 disables periodic resend

Ports:
pclk  in  1  pixel clock (75 MHz), sole clock
rst  in  1  asynchronous, active-low reset
score_bcd  in  4*DIGITS  local score, BCD, MS digit in top nibble
send_req  in  1  1-cycle pulse: force a frame
tx_busy  in  1  UART transmitter busy
tx_data  out  8  byte to UART
tx_wr  out  1  1-cycle write strobe
rx_data  in  8  received byte
rx_rdy  in  1  UART byte-ready level
rx_rdy_clr  out  1  1-cycle clear of rx_rdy
peer_score  out  4*DIGITS  last valid peer score
peer_valid  out  1  1-cycle pulse when peer_score updates
rx_err  out  1  1-cycle pulse on framing error
tx_active  out  1  high while a frame is in progress

Behaviour:
- Reset (rst=0, async): all outputs 0; tx FSM TX_IDLE; rx FSM RX_HDR; last_sent=0; refresh counter=0; pending=0.
- Frame format (DIGITS+3 bytes): HDR_CHAR, DIGITS ASCII digits MS first (8'h30+nibble; any nibble >9 sent as 8'h3F '?'), 8'h0D, 8'h0A.
- Trigger: pending is set when score_bcd != last_sent, when send_req=1, or when the refresh counter reaches REFRESH_CYCLES-1 (counter then wraps to 0; it also clears on every frame start).
- TX FSM: TX_IDLE -> TX_SEND when pending=1; on entry snapshot score_bcd into last_sent, clear pending, byte index=0.
- TX_SEND: drive tx_data, tx_wr=1 for exactly one cycle -> TX_GUARD.
- TX_GUARD: one cycle, tx_busy ignored -> TX_WAIT.
- TX_WAIT: hold until tx_busy=0; then index+1 -> TX_SEND, or after the final LF -> TX_IDLE.
- Back-to-back frames: pending raised mid-frame is serviced immediately after LF; TX_IDLE lasts 1 cycle.
- Snapshot is fixed for the whole frame; no tearing. tx_active=1 in every state except TX_IDLE.
- Latency: score change at cycle N -> first tx_wr at N+2 if idle and tx_busy=0.
- RX: a byte is accepted in a cycle with rx_rdy=1 and rx_rdy_clr=0; rx_rdy_clr pulses the following cycle. At most one byte every 2 cycles.
- RX FSM: RX_HDR waits for HDR_CHAR -> RX_DIG, digit count=0.
- RX_DIG: an ASCII '0'..'9' shifts its nibble into a shadow register; after DIGITS digits -> RX_CR.
- RX_CR expects 8'h0D -> RX_LF. RX_LF expects 8'h0A: peer_score<=shadow, peer_valid pulse -> RX_HDR.
- Any unexpected byte outside RX_HDR: rx_err pulse. The next state is RX_DIG (count 0, shadow cleared) if that byte is HDR_CHAR, else RX_HDR. Bytes other than HDR_CHAR in RX_HDR are silently dropped.
- peer_score holds its value until the next complete valid frame. The shadow register never leaks to the output.
- TX and RX are fully independent and may run simultaneously.
- Reset mid-frame aborts both FSMs. No partial-frame completion; tx_wr drops asynchronously.

Decomposition:
- Shared package score_link_pkg: ASCII constants (CR, LF, ZERO, QMARK), TX and RX state encodings, function bcd_to_ascii(nibble).
- One natural sub-module: score_link_rx_parser (RX FSM, shadow register, peer outputs). The TX sequencer stays in the top.

Test Plan:
- score_bcd 24'h000000 -> 24'h001234, tx_busy model 10 cycles per byte -> tx_wr bytes 53 30 30 31 32 33 34 0D 0A, no tx_wr while tx_busy=1.
- score_bcd changes to 24'h000099 at byte 3 of a frame -> current frame still carries the old snapshot, then a second frame with 30 30 30 30 39 39 follows.
- score_bcd 24'h00A001 -> digit '?' (3F) in position 3; idle with REFRESH_CYCLES=100 -> a frame starts every 100 cycles.
- rx bytes 53 30 30 35 30 30 37 0D 0A -> peer_valid pulse, peer_score=24'h005007, rx_rdy_clr pulsed 9 times.
- rx bytes 53 31 32 53 30 30 30 30 30 31 0D 0A -> one rx_err at the second 53, then peer_score=24'h000001; rx 53 31 41 -> rx_err, peer_score unchanged.
- rst asserted mid-frame at byte 4 -> tx_wr=0, tx_active=0 immediately; after release, a full frame is resent from the header because last_sent=0 differs from the score.
